// File: rtl/range_stream_driver.sv
// Frames an upstream valid/ready sample stream into go/data/finish bursts for a RangeFinder and latches its result.
// Optional shadow min/max cross-check of the returned range is enabled by defining RANGE_CHECK_EN.
module range_stream_driver #(
    parameter int WIDTH     = 12,
    parameter int BURST_LEN = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             go,
    output logic             finish,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] range_in,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
`ifdef RANGE_CHECK_EN
    output logic             range_error,
`endif
    output logic             busy
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        STREAM,
        CAPTURE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             capLate_q, capLate_d;
    logic             transfer;

    assign sample_ready = (state_q == ARMED) || (state_q == STREAM);
    assign transfer     = sample_valid && sample_ready;
    assign busy         = (state_q != IDLE);
    assign go           = go_q;
    assign finish       = finish_q;
    assign data_out     = data_q;
    assign result       = result_q;
    assign result_valid = valid_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        go_d      = 1'b0;
        finish_d  = 1'b0;
        data_d    = data_q;
        result_d  = result_q;
        valid_d   = valid_q;
        capLate_d = capLate_q;
        case (state_q)
            IDLE: begin
                if (start && !valid_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (transfer) begin
                    data_d  = sample_in;
                    go_d    = 1'b1;
                    count_d = CW'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (transfer) begin
                    data_d  = sample_in;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        finish_d  = 1'b1;
                        capLate_d = 1'b0;
                        state_d   = CAPTURE;
                    end
                end
            end
            // The RangeFinder presents its range one cycle after finish, so wait a cycle before latching.
            CAPTURE: begin
                if (!capLate_q) begin
                    capLate_d = 1'b1;
                end else begin
                    result_d  = range_in;
                    valid_d   = 1'b1;
                    capLate_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            go_q      <= 1'b0;
            finish_q  <= 1'b0;
            data_q    <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            capLate_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            go_q      <= go_d;
            finish_q  <= finish_d;
            data_q    <= data_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            capLate_q <= capLate_d;
        end
    end

`ifdef RANGE_CHECK_EN
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] span;
    logic             rangeErr_q, rangeErr_d;

    assign span        = max_q - min_q;
    assign range_error = rangeErr_q;

    // Shadow extremes follow only transferred samples; stall repeats cannot move them anyway.
    always_comb begin
        min_d      = min_q;
        max_d      = max_q;
        rangeErr_d = rangeErr_q;
        if (transfer) begin
            if (state_q == ARMED) begin
                min_d = sample_in;
                max_d = sample_in;
            end else begin
                if (sample_in < min_q) min_d = sample_in;
                if (sample_in > max_q) max_d = sample_in;
            end
        end
        if (state_q == CAPTURE && capLate_q) begin
            rangeErr_d = (range_in != span);
        end
        if (state_q == HOLD && result_ack) begin
            rangeErr_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            min_q      <= '0;
            max_q      <= '0;
            rangeErr_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            rangeErr_q <= rangeErr_d;
        end
    end
`endif

endmodule

// File: tb/tb_range_stream_driver.sv
// Self-checking bench for range_stream_driver: two instances (BURST_LEN 4 and 16), a behavioural RangeFinder
// model per instance, a vector table and a result scoreboard.
module tb_range_stream_driver;

    localparam int WIDTH = 12;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             resetSig    [2];
    logic             startReq    [2];
    logic [WIDTH-1:0] sampleIn    [2];
    logic             sampleValid [2];
    logic             sampleReady [2];
    logic             goSig       [2];
    logic             finishSig   [2];
    logic [WIDTH-1:0] dataOut     [2];
    logic [WIDTH-1:0] rangeIn     [2];
    logic [WIDTH-1:0] resultSig   [2];
    logic             resultValid [2];
    logic             resultAck   [2];
    logic             busySig     [2];
`ifdef RANGE_CHECK_EN
    logic             rangeError  [2];
`endif

    range_stream_driver #(.WIDTH(WIDTH), .BURST_LEN(4)) dut4 (
        .clock(clock), .reset(resetSig[0]), .start(startReq[0]),
        .sample_in(sampleIn[0]), .sample_valid(sampleValid[0]), .sample_ready(sampleReady[0]),
        .go(goSig[0]), .finish(finishSig[0]), .data_out(dataOut[0]), .range_in(rangeIn[0]),
        .result(resultSig[0]), .result_valid(resultValid[0]), .result_ack(resultAck[0]),
`ifdef RANGE_CHECK_EN
        .range_error(rangeError[0]),
`endif
        .busy(busySig[0])
    );

    range_stream_driver #(.WIDTH(WIDTH), .BURST_LEN(16)) dut16 (
        .clock(clock), .reset(resetSig[1]), .start(startReq[1]),
        .sample_in(sampleIn[1]), .sample_valid(sampleValid[1]), .sample_ready(sampleReady[1]),
        .go(goSig[1]), .finish(finishSig[1]), .data_out(dataOut[1]), .range_in(rangeIn[1]),
        .result(resultSig[1]), .result_valid(resultValid[1]), .result_ack(resultAck[1]),
`ifdef RANGE_CHECK_EN
        .range_error(rangeError[1]),
`endif
        .busy(busySig[1])
    );

    typedef struct {
        int         dutSel;
        int         len;
        logic [11:0] smp [16];
        int         stallAt;
        int         stallLen;
        logic [11:0] expResult;
        logic       expErr;
        logic       forceBad;
    } vec_t;

    typedef struct {
        int          dutSel;
        logic [11:0] res;
        logic        err;
    } exp_t;

    vec_t        vecs [8];
    exp_t        sbq [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          goCount  [2] = '{0, 0};
    int          finCount [2] = '{0, 0};
    int          finCyc   [2] = '{0, 0};
    int          goBase   [2] = '{0, 0};
    int          finBase  [2] = '{0, 0};
    logic [11:0] lastResult [2];
    logic        forceBad = 1'b0;
    logic [11:0] mn [2];
    logic [11:0] mx [2];
    logic        run [2];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural RangeFinder: min/max over every cycle from go through finish, range valid the cycle after.
    always @(posedge clock) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (resetSig[i]) begin
                run[i] = 1'b0;
                rangeIn[i] <= '0;
            end else if (goSig[i]) begin
                mn[i]  = dataOut[i];
                mx[i]  = dataOut[i];
                run[i] = 1'b1;
            end else if (run[i]) begin
                if (dataOut[i] < mn[i]) mn[i] = dataOut[i];
                if (dataOut[i] > mx[i]) mx[i] = dataOut[i];
                if (finishSig[i]) begin
                    run[i] = 1'b0;
                    rangeIn[i] <= forceBad ? 12'd5 : (mx[i] - mn[i]);
                end
            end
        end
    end

    // Pulse monitor on registered outputs.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (goSig[i]) goCount[i]++;
            if (finishSig[i]) begin
                finCount[i]++;
                finCyc[i] = cyc;
            end
            if (goSig[i] && finishSig[i]) checkOutput("go_finish_exclusive", 1, 0);
        end
    end

    task automatic setVec(input int idx, input int stallAt, input int stallLen, input int expRes,
                          input logic expErr, input logic fb,
                          input int s0, input int s1, input int s2, input int s3);
        vecs[idx].dutSel    = 0;
        vecs[idx].len       = 4;
        vecs[idx].stallAt   = stallAt;
        vecs[idx].stallLen  = stallLen;
        vecs[idx].expResult = 12'(expRes);
        vecs[idx].expErr    = expErr;
        vecs[idx].forceBad  = fb;
        for (int k = 0; k < 16; k++) vecs[idx].smp[k] = '0;
        vecs[idx].smp[0] = 12'(s0);
        vecs[idx].smp[1] = 12'(s1);
        vecs[idx].smp[2] = 12'(s2);
        vecs[idx].smp[3] = 12'(s3);
    endtask

    task automatic applyStimulus(input int v);
        int d;
        int guard;
        exp_t e;
        d = vecs[v].dutSel;
        forceBad = vecs[v].forceBad;
        e.dutSel = d;
        e.res    = vecs[v].expResult;
        e.err    = vecs[v].expErr;
        sbq.push_back(e);
        goBase[d]  = goCount[d];
        finBase[d] = finCount[d];
        @(negedge clock);
        startReq[d] = 1'b1;
        @(negedge clock);
        startReq[d] = 1'b0;
        checkOutput("busy_armed", busySig[d], 1);
        for (int k = 0; k < vecs[v].len; k++) begin
            if (k == vecs[v].stallAt && k > 0) begin
                sampleValid[d] = 1'b0;
                for (int s = 0; s < vecs[v].stallLen; s++) begin
                    @(negedge clock);
                    checkOutput("stall_data_hold", dataOut[d], vecs[v].smp[k-1]);
                    checkOutput("stall_no_finish", finishSig[d], 0);
                end
            end
            sampleIn[d]    = vecs[v].smp[k];
            sampleValid[d] = 1'b1;
            guard = 0;
            while (!sampleReady[d] && guard < 20) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 20) checkOutput("ready_timeout", sampleReady[d], 1);
            @(negedge clock);
            checkOutput("data_out", dataOut[d], vecs[v].smp[k]);
            if (k == 0) begin
                checkOutput("go_first", goSig[d], 1);
                checkOutput("result_retained", resultSig[d], lastResult[d]);
            end
            if (k == vecs[v].len - 1) checkOutput("finish_last", finishSig[d], 1);
            checkOutput("ready_after_xfer", sampleReady[d], (k < vecs[v].len - 1) ? 1 : 0);
        end
        sampleValid[d] = 1'b0;
    endtask

    task automatic ackResult(input int d);
        resultAck[d] = 1'b1;
        @(negedge clock);
        resultAck[d] = 1'b0;
        checkOutput("valid_cleared", resultValid[d], 0);
        checkOutput("idle_after_ack", busySig[d], 0);
        checkOutput("result_kept", resultSig[d], lastResult[d]);
`ifdef RANGE_CHECK_EN
        checkOutput("range_error_cleared", rangeError[d], 0);
`endif
    endtask

    task automatic waitResult(input int d, input bit doAck);
        int guard;
        exp_t e;
        guard = 0;
        while (!resultValid[d] && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 60) checkOutput("result_timeout", resultValid[d], 1);
        if (sbq.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            checkOutput("result", resultSig[d], e.res);
            checkOutput("finish_to_valid", cyc - finCyc[d], 2);
            checkOutput("go_pulses", goCount[d] - goBase[d], 1);
            checkOutput("finish_pulses", finCount[d] - finBase[d], 1);
`ifdef RANGE_CHECK_EN
            checkOutput("range_error", rangeError[d], e.err);
`endif
            lastResult[d] = e.res;
        end
        repeat (2) begin
            @(negedge clock);
            checkOutput("valid_held", resultValid[d], 1);
        end
        if (doAck) ackResult(d);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            resetSig[i] = 1'b1; startReq[i] = 1'b0; sampleIn[i] = '0;
            sampleValid[i] = 1'b0; resultAck[i] = 1'b0; lastResult[i] = '0;
        end

        setVec(0, -1, 0, 47, 1'b0, 1'b0, 10, 50, 3, 20);
        setVec(1, 2, 3, 47, 1'b0, 1'b0, 10, 50, 3, 20);
        setVec(2, -1, 0, 0, 1'b0, 1'b0, 100, 100, 100, 100);
        setVec(3, -1, 0, 4095, 1'b0, 1'b0, 0, 4095, 7, 8);
        setVec(4, 1, 1, 3, 1'b0, 1'b0, 5, 6, 7, 8);
`ifdef RANGE_CHECK_EN
        setVec(7, -1, 0, 5, 1'b1, 1'b1, 0, 9, 9, 0);
`else
        setVec(7, -1, 0, 9, 1'b0, 1'b0, 0, 9, 9, 0);
`endif
        for (int v = 5; v <= 6; v++) begin
            vecs[v].dutSel   = 1;
            vecs[v].len      = 16;
            vecs[v].expErr   = 1'b0;
            vecs[v].forceBad = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            vecs[5].smp[k] = 12'hFFF;
            vecs[6].smp[k] = 12'(k * 100);
        end
        vecs[5].stallAt = -1; vecs[5].stallLen = 0; vecs[5].expResult = 12'd0;
        vecs[6].stallAt = 5;  vecs[6].stallLen = 2; vecs[6].expResult = 12'd1500;

        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_go", goSig[i], 0);
            checkOutput("reset_finish", finishSig[i], 0);
            checkOutput("reset_ready", sampleReady[i], 0);
            checkOutput("reset_valid", resultValid[i], 0);
            checkOutput("reset_busy", busySig[i], 0);
            checkOutput("reset_data", dataOut[i], 0);
            checkOutput("reset_result", resultSig[i], 0);
`ifdef RANGE_CHECK_EN
            checkOutput("reset_range_error", rangeError[i], 0);
`endif
            resetSig[i] = 1'b0;
        end

        // Start while holding a result must be ignored; the held result survives into the next burst.
        applyStimulus(0);
        waitResult(0, 1'b0);
        startReq[0] = 1'b1;
        @(negedge clock);
        startReq[0] = 1'b0;
        @(negedge clock);
        checkOutput("hold_start_valid", resultValid[0], 1);
        checkOutput("hold_start_ready", sampleReady[0], 0);
        checkOutput("hold_start_no_go", goCount[0] - goBase[0], 1);
        checkOutput("hold_start_result", resultSig[0], 47);
        ackResult(0);
        applyStimulus(4);
        waitResult(0, 1'b1);

        // Reset in the middle of a burst after two transfers abandons it without finish.
        finBase[0] = finCount[0];
        @(negedge clock);
        startReq[0] = 1'b1;
        @(negedge clock);
        startReq[0] = 1'b0;
        sampleIn[0] = 12'd10; sampleValid[0] = 1'b1;
        @(negedge clock);
        sampleIn[0] = 12'd50;
        @(negedge clock);
        sampleValid[0] = 1'b0;
        checkOutput("pre_reset_data", dataOut[0], 50);
        resetSig[0] = 1'b1;
        @(negedge clock);
        resetSig[0] = 1'b0;
        checkOutput("midreset_busy", busySig[0], 0);
        checkOutput("midreset_ready", sampleReady[0], 0);
        checkOutput("midreset_data", dataOut[0], 0);
        checkOutput("midreset_result", resultSig[0], 0);
        checkOutput("midreset_go", goSig[0], 0);
        checkOutput("midreset_no_finish", finCount[0] - finBase[0], 0);
        lastResult[0] = '0;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(v);
            waitResult(vecs[v].dutSel, 1'b1);
        end
        forceBad = 1'b0;
        checkOutput("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/range_stream_driver.md
Name: range_stream_driver

Overview:
- Producer side of the RangeFinder measurement interface: frames an external sample stream into go/data/finish bursts and collects the returned range.
- Accepts samples over a valid/ready handshake and emits exactly BURST_LEN samples per measurement, with go on the first sample and finish on the last.
- Latches the range result and holds it until acknowledged. Sits between the chip's input pins and the RangeFinder instance.

Parameters:
- WIDTH, 12, sample width and range width.
- BURST_LEN, 16, samples per measurement; legal range 2..4095 (go and finish are never asserted in the same cycle).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request one measurement; sampled only in IDLE
- sample_in  input  WIDTH  upstream sample
- sample_valid  input  1  sample_in valid
- sample_ready  output  1  sample accepted this cycle (valid & ready = transfer)
- go  output  WIDTH-independent 1  to RangeFinder: first sample of burst
- finish  output  1  to RangeFinder: last sample of burst
- data_out  output  WIDTH  to RangeFinder data_in
- range_in  input  WIDTH  from RangeFinder range
- result  output  WIDTH  latched range
- result_valid  output  1  result holds a fresh measurement
- result_ack  input  1  consumer takes result
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE; go, finish, sample_ready, result_valid, busy = 0; data_out = 0; result = 0; sample count = 0. Reset mid-burst abandons the burst with no finish issued.
- Interface: go, finish and data_out are registered. RangeFinder samples data_out every cycle between go and finish inclusive, and its range is valid the cycle after finish.
- IDLE:
  - sample_ready=0.
  - start=1 and result_valid=0 → ARMED.
  - start while result_valid=1 is ignored (no latching).
- ARMED:
  - sample_ready=1.
  - On valid&ready: data_out<=sample_in, go<=1 for exactly one cycle, count<=1 → STREAM.
- STREAM:
  - sample_ready=1.
  - On transfer: data_out<=sample_in, count<=count+1.
  - If the transfer makes count==BURST_LEN: finish<=1 for one cycle, sample_ready drops to 0 the next cycle → CAPTURE.
  - sample_valid=0 (stall): data_out holds its previous value and count does not advance. Repeated samples do not change min/max, so stalls are harmless.
- CAPTURE:
  - Entered the cycle finish is high. Next cycle: result<=range_in, result_valid<=1 → HOLD.
- HOLD:
  - result_valid=1 until result_ack; on ack, result_valid<=0 next cycle → IDLE. result is retained after ack.
  - result_ack in any other state is ignored.
- Latency: start to go ≥1 cycle (ARMED entry) plus the first valid; finish to result_valid = 2 cycles.
- Counter is clog2(BURST_LEN+1) bits; never wraps within a burst.
- go and finish are never both 1. No go is issued while busy from a prior burst.

Optional Feature:
- RANGE_CHECK_EN defined:
  - Shadow min/max registers track every transferred sample (init on go sample). In CAPTURE, range_in is compared with max−min (WIDTH-bit unsigned).
  - Adds output range_error (1 bit, reset 0): set with result_valid on mismatch, cleared with result_valid.
- Not defined: no shadow logic, range_error port absent.

Test Plan:
- BURST_LEN=4, start, samples 10,50,3,20 back-to-back → go with 10, finish with 20, 4 ready handshakes, result=47 two cycles after finish, result_valid held until ack.
- Same burst with sample_valid low 3 cycles after sample 50 → data_out holds 50 during stall, count stays 2, result still 47.
- start pulsed while HOLD (result_valid=1) → ignored; after ack, start again → new burst with go; first result unchanged until new capture.
- reset asserted during STREAM at count=2 → next cycle all outputs 0, state IDLE; a fresh start produces a full 4-sample burst with go.
- Samples all 0xFFF, BURST_LEN=16 → result=0, exactly one go and one finish, 16 transfers.
- RANGE_CHECK_EN, model forcing range_in=5 for samples 0,9 → range_error=1 alongside result_valid; cleared after ack.
